// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder
//
// Scans a 4x4 active-low matrix keypad, debounces the contact and encodes
// the accepted key as row_idx*4 + col_idx.
//
// Parameters
//   SCAN_DIV  clock cycles each column stays driven (>= 4)
//   DEBOUNCE  consecutive matching end-of-dwell samples to accept a
//             press or a release (>= 1)
//
// Ports
//   clk      system clock
//   rst_n    synchronous active-low reset
//   rows     keypad rows, active-low, asynchronous to clk
//   cols     column drive, active-low, exactly one bit low
//   key      code of the last accepted key
//   valid    one-cycle pulse when a new key is accepted
//   pressed  high while an accepted key is held
module keypad_scan_encoder #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       valid,
    output logic       pressed
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_HELD,
        S_RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       rows_s1_q, rows_s2_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_q, col_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cap_row_q, cap_row_d;
    logic [1:0]       cap_col_q, cap_col_d;
    logic [3:0]       key_q, key_d;
    logic             valid_q, valid_d;
    logic             pressed_q, pressed_d;

    logic             tick;
    logic             row_onehot;
    logic [1:0]       row_idx;
    logic             rows_idle;
    logic [CNT_W-1:0] cnt_inc;

    assign tick      = (div_q == DIV_LAST);
    assign rows_idle = (rows_s2_q == 4'hF);
    assign cnt_inc   = cnt_q + CNT_ONE;

    // Exactly one low row is a usable sample; multi-key reads as no key.
    always_comb begin
        row_onehot = 1'b0;
        row_idx    = 2'd0;
        case (rows_s2_q)
            4'b1110: begin row_onehot = 1'b1; row_idx = 2'd0; end
            4'b1101: begin row_onehot = 1'b1; row_idx = 2'd1; end
            4'b1011: begin row_onehot = 1'b1; row_idx = 2'd2; end
            4'b0111: begin row_onehot = 1'b1; row_idx = 2'd3; end
            default: ;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_SCAN;
            rows_s1_q <= 4'hF;
            rows_s2_q <= 4'hF;
            div_q     <= '0;
            col_q     <= '0;
            cnt_q     <= '0;
            cap_row_q <= '0;
            cap_col_q <= '0;
            key_q     <= '0;
            valid_q   <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rows_s1_q <= rows;
            rows_s2_q <= rows_s1_q;
            div_q     <= div_d;
            col_q     <= col_d;
            cnt_q     <= cnt_d;
            cap_row_q <= cap_row_d;
            cap_col_q <= cap_col_d;
            key_q     <= key_d;
            valid_q   <= valid_d;
            pressed_q <= pressed_d;
        end
    end

    // Next-state logic; everything except the dwell counter moves on ticks only.
    always_comb begin
        state_d   = state_q;
        div_d     = tick ? '0 : div_q + DIV_W'(1);
        col_d     = col_q;
        cnt_d     = cnt_q;
        cap_row_d = cap_row_q;
        cap_col_d = cap_col_q;
        key_d     = key_q;
        valid_d   = 1'b0;
        pressed_d = pressed_q;

        if (tick) begin
            case (state_q)
                S_SCAN: begin
                    if (row_onehot) begin
                        cap_row_d = row_idx;
                        cap_col_d = col_q;
                        cnt_d     = CNT_ONE;
                        if (CNT_DONE == CNT_ONE) begin
                            key_d     = {row_idx, col_q};
                            valid_d   = 1'b1;
                            pressed_d = 1'b1;
                            state_d   = S_HELD;
                        end else begin
                            state_d   = S_DEBOUNCE;
                        end
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end

                S_DEBOUNCE: begin
                    // Column is frozen here, so the same row means the same key.
                    if (row_onehot && (row_idx == cap_row_q)) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            key_d     = {cap_row_q, cap_col_q};
                            valid_d   = 1'b1;
                            pressed_d = 1'b1;
                            state_d   = S_HELD;
                        end
                    end else begin
                        state_d = S_SCAN;
                        col_d   = col_q + 2'd1;
                    end
                end

                S_HELD: begin
                    if (rows_idle) begin
                        cnt_d = CNT_ONE;
                        if (CNT_DONE == CNT_ONE) begin
                            pressed_d = 1'b0;
                            state_d   = S_SCAN;
                            col_d     = col_q + 2'd1;
                        end else begin
                            state_d   = S_RELEASE;
                        end
                    end
                end

                S_RELEASE: begin
                    if (rows_idle) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            pressed_d = 1'b0;
                            state_d   = S_SCAN;
                            col_d     = col_q + 2'd1;
                        end
                    end else begin
                        state_d = S_HELD;
                    end
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        cols    = ~(4'b0001 << col_q);
        key     = key_q;
        valid   = valid_q;
        pressed = pressed_q;
    end

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Testbench for keypad_scan_encoder (SCAN_DIV=4, DEBOUNCE=3).
// A keypad model pulls a row low whenever a held key's column is driven.
// Accepted keys are expected through a scoreboard queue checked on valid.
module tb_keypad_scan_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key;
    logic        valid;
    logic        pressed;

    logic [15:0] key_mask = '0;   // bit r*4+c set = key (row r, col c) held
    int          checks   = 0;
    int          failures = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  sb_exp;

    typedef struct {
        logic [15:0] mask;
        bit          accept;
        logic [3:0]  exp_key;
    } vec_t;

    vec_t vecs[7];

    keypad_scan_encoder #(
        .SCAN_DIV(4),
        .DEBOUNCE(3)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rows   (rows),
        .cols   (cols),
        .key    (key),
        .valid  (valid),
        .pressed(pressed)
    );

    always #5 clk = ~clk;

    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_mask[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [3:0] col_pat(input int idx);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << idx);
    endfunction

    // Leaves rst_n released at a negedge where the dwell counter is 0.
    task automatic do_reset(input bit chk);
        @(negedge clk);
        rst_n    = 1'b0;
        key_mask = '0;
        cyc(3);
        if (chk) begin
            check("rst_cols", cols, 4'b1110);
            check("rst_key", key, 4'h0);
            check("rst_valid", valid, 1'b0);
            check("rst_pressed", pressed, 1'b0);
        end
        rst_n = 1'b1;
    endtask

    // Scoreboard: every valid pulse must match the oldest expected key.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_valid: got key %0d expected no valid at %0t", key, $time);
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_key", key, sb_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'h8000, 1'b1, 4'd15};
        vecs[1] = '{16'h0040, 1'b1, 4'd6};
        vecs[2] = '{16'h0110, 1'b0, 4'd6};
        vecs[3] = '{16'h0008, 1'b1, 4'd3};
        vecs[4] = '{16'h0001, 1'b1, 4'd0};
        vecs[5] = '{16'h0200, 1'b1, 4'd9};
        vecs[6] = '{16'h8008, 1'b0, 4'd9};

        // Reset and idle scanning
        do_reset(1'b1);
        for (int k = 0; k < 20; k++) begin
            check("scan_cols", cols, col_pat((k / 4) % 4));
            cyc(1);
        end

        // Clean press of row 2 / col 1, exact latency
        do_reset(1'b0);
        key_mask = 16'h0200;
        exp_q.push_back(4'd9);
        for (int k = 0; k < 18; k++) begin
            if (k == 15 || k == 16 || k == 17) begin
                check("press_valid", valid, (k == 16));
                check("press_pressed", pressed, (k >= 16));
            end
            if (k >= 8) check("press_cols_frozen", cols, 4'b1101);
            if (k == 16) check("press_key", key, 4'd9);
            cyc(1);
        end
        cyc(78);                                 // k = 96, 20 ticks held
        check("hold_pressed", pressed, 1'b1);
        check("hold_key", key, 4'd9);
        check("hold_cols", cols, 4'b1101);

        // Release glitch: 2 idle ticks, re-press, then a full release
        key_mask = '0;
        cyc(8);
        check("glitch_pressed_a", pressed, 1'b1);
        key_mask = 16'h0200;
        cyc(4);
        check("glitch_pressed_b", pressed, 1'b1);
        key_mask = '0;
        cyc(11);
        check("release_pressed_late", pressed, 1'b1);
        cyc(1);
        check("release_pressed", pressed, 1'b0);
        check("release_key", key, 4'd9);
        check("release_cols", cols, 4'b1011);

        // Bounce: only 2 matching ticks
        do_reset(1'b0);
        key_mask = 16'h0200;
        cyc(12);
        check("bounce_pressed_mid", pressed, 1'b0);
        key_mask = '0;
        cyc(3);
        check("bounce_cols_hold", cols, 4'b1101);
        cyc(1);
        check("bounce_cols", cols, 4'b1011);
        check("bounce_pressed", pressed, 1'b0);
        check("bounce_key", key, 4'd0);
        cyc(4);
        check("bounce_cols_next", cols, 4'b0111);

        // Multi-key in column 0 keeps scanning
        do_reset(1'b0);
        key_mask = 16'h0110;
        for (int t = 0; t < 10; t++) begin
            check("multi_cols", cols, col_pat(t % 4));
            cyc(4);
        end
        check("multi_pressed", pressed, 1'b0);
        check("multi_key", key, 4'd0);

        // Reset while a key is held
        do_reset(1'b0);
        key_mask = 16'h0200;
        exp_q.push_back(4'd9);
        cyc(20);
        check("midrst_pressed_before", pressed, 1'b1);
        rst_n = 1'b0;
        cyc(1);
        check("midrst_pressed", pressed, 1'b0);
        check("midrst_key", key, 4'd0);
        check("midrst_cols", cols, 4'b1110);
        check("midrst_valid", valid, 1'b0);

        // Table of keys, loose timing
        do_reset(1'b0);
        for (int i = 0; i < 7; i++) begin
            key_mask = vecs[i].mask;
            if (vecs[i].accept) exp_q.push_back(vecs[i].exp_key);
            cyc(60);
            check("tbl_pressed", pressed, vecs[i].accept);
            check("tbl_key", key, vecs[i].exp_key);
            key_mask = '0;
            cyc(40);
            check("tbl_released", pressed, 1'b0);
            check("tbl_key_kept", key, vecs[i].exp_key);
        end

        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
